// File: rtl/eth_tx_arbiter_pkg.sv
// Shared types and helpers for the eth TX arbiter slice.
package eth_tx_arbiter_pkg;

    localparam int unsigned ETH_DW      = 8;
    localparam int unsigned MAX_CLIENTS = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    // Index of the set bit in a one-hot (or zero) vector of up to MAX_CLIENTS bits.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_CLIENTS-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_CLIENTS; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after i_ptr, wrapping mod N.
module rr_pick
    import eth_tx_arbiter_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    // Scan ptr+1 .. ptr+N and keep only the first hit.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            w_idx = PW'((32'(i_ptr) + i) % N);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing the eth byte write port between
// N clients, with an idle watchdog that revokes a stalled grant.
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_CLIENTS = 2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_CLIENTS-1:0]          i_req,
    input  logic [ETH_DW*N_CLIENTS-1:0]   i_wdata,
    input  logic [N_CLIENTS-1:0]          i_wvalid,
    input  logic [N_CLIENTS-1:0]          i_wlast,
    output logic [N_CLIENTS-1:0]          o_wready,
    output logic [N_CLIENTS-1:0]          o_grant,
    output logic [N_CLIENTS-1:0]          o_abort,
    output logic [ETH_DW-1:0]             o_wdata,
    output logic                          o_wvalid,
    output logic                          o_wlast,
    input  logic                          i_wready,
    output logic                          o_busy
);

    localparam int unsigned   PW         = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int unsigned   TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    arb_state_t            r_state, w_state_nx;
    logic [N_CLIENTS-1:0]  r_grant, w_grant_nx;
    logic [N_CLIENTS-1:0]  r_abort, w_abort_nx;
    logic [PW-1:0]         r_ptr, w_ptr_nx;
    logic [TW-1:0]         r_timer, w_timer_nx;

    logic [N_CLIENTS-1:0]  w_pick;
    logic [PW-1:0]         w_gidx;
    logic [ETH_DW-1:0]     w_lane [N_CLIENTS];
    logic [ETH_DW-1:0]     w_wdata;
    logic                  w_wvalid;
    logic                  w_wlast;
    logic                  w_accept;
    logic                  w_req_held;
    logic                  w_expire;

    rr_pick #(.N(N_CLIENTS)) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick)
    );

    // Each client's byte is masked by its own grant bit before merging, so
    // non-granted data can never reach the eth port.
    for (genvar g = 0; g < N_CLIENTS; g++) begin : g_lane
        assign w_lane[g] = i_wdata[g*ETH_DW +: ETH_DW] & {ETH_DW{r_grant[g]}};
    end

    // OR-merge of the masked lanes and the handshake pass-through.
    always_comb begin
        w_wdata = '0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            w_wdata = w_wdata | w_lane[i];
        end
        w_req_held = |(r_grant & i_req);
        w_wvalid   = |(r_grant & i_wvalid & i_req);
        w_wlast    = (|(r_grant & i_wlast)) & w_wvalid;
        w_accept   = w_wvalid & i_wready;
        w_expire   = (TIMEOUT != 0) && (r_timer == TIMER_LAST);
        w_gidx     = PW'(onehot_to_idx(MAX_CLIENTS'(r_grant)));
    end

    // Next-state: grant on request in IDLE; in XFER release on last beat,
    // request drop or watchdog expiry (last beat takes priority).
    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_ptr_nx   = r_ptr;
        w_timer_nx = r_timer;
        w_abort_nx = '0;
        case (r_state)
            ST_IDLE: begin
                if (|i_req) begin
                    w_grant_nx = w_pick;
                    w_state_nx = ST_XFER;
                    w_timer_nx = '0;
                end
            end
            ST_XFER: begin
                if (w_accept && w_wlast) begin
                    w_grant_nx = '0;
                    w_ptr_nx   = w_gidx;
                    w_state_nx = ST_IDLE;
                end else if (!w_req_held) begin
                    w_grant_nx = '0;
                    w_ptr_nx   = w_gidx;
                    w_state_nx = ST_IDLE;
                end else if (w_accept) begin
                    w_timer_nx = '0;
                end else if (w_expire) begin
                    w_grant_nx = '0;
                    w_abort_nx = r_grant;
                    w_ptr_nx   = w_gidx;
                    w_state_nx = ST_IDLE;
                end else if (r_timer != '1) begin
                    w_timer_nx = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_grant_nx = '0;
            end
        endcase
    end

    // State, grant, pointer, watchdog and abort-pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_abort <= '0;
            r_ptr   <= PW'(N_CLIENTS - 1);
            r_timer <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_abort <= w_abort_nx;
            r_ptr   <= w_ptr_nx;
            r_timer <= w_timer_nx;
        end
    end

    assign o_grant  = r_grant;
    assign o_abort  = r_abort;
    assign o_busy   = (r_state == ST_XFER);
    assign o_wdata  = w_wdata;
    assign o_wvalid = w_wvalid;
    assign o_wlast  = w_wlast;
    assign o_wready = r_grant & {N_CLIENTS{i_wready}};

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: directed steps followed by randomized frames
// checked against a frame-order scoreboard.
module tb_eth_tx_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [7:0]     wd [N];
    logic [8*N-1:0] wdata;
    logic [N-1:0]   wvalid;
    logic [N-1:0]   wlast;
    logic           wready;
    logic [N-1:0]   o_wready, o_grant, o_abort;
    logic [7:0]     o_wdata;
    logic           o_wvalid, o_wlast, o_busy;

    int total = 0;
    int bad   = 0;

    // Random-phase data: per-client byte streams, frame boundaries and the
    // expected eth byte stream in round-robin frame order.
    logic [7:0] cdat  [N][32];
    bit         clast [N][32];
    int         clen  [N];
    int         cpos  [N];
    int         nfr   [N];
    int         fst   [N][5];
    int         fln   [N][5];
    int         fdone [N];
    int         exp_own [64];
    logic [7:0] exp_dat [64];
    bit         exp_lst [64];
    int         en, ei, stall, rptr, left, pick;
    bit         after_last, go;
    logic [7:0] bb  [4];
    logic [7:0] cap [8];
    int         ncap, nb;
    logic [N-1:0] oh;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_wd
        assign wdata[g*8 +: 8] = wd[g];
    end

    eth_tx_arbiter #(.N_CLIENTS(N), .TIMEOUT(TO)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_wdata  (wdata),
        .i_wvalid (wvalid),
        .i_wlast  (wlast),
        .o_wready (o_wready),
        .o_grant  (o_grant),
        .o_abort  (o_abort),
        .o_wdata  (o_wdata),
        .o_wvalid (o_wvalid),
        .o_wlast  (o_wlast),
        .i_wready (wready),
        .o_busy   (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; wvalid = '0; wlast = '0; wready = 1'b0;
        for (int i = 0; i < N; i++) wd[i] = 8'h00;
        adv(); adv();

        // Reset state, then release with clients 0 and 1 requesting.
        req = 3'b011;
        settle();
        check("rst_grant", o_grant, 0);
        check("rst_busy", o_busy, 0);
        check("rst_abort", o_abort, 0);
        check("rst_wvalid", o_wvalid, 0);
        check("rst_wready", o_wready, 0);
        check("rst_wdata", o_wdata, 0);
        adv();
        rst = 1'b0;
        settle();
        check("rel_idle_grant", o_grant, 0);
        adv();

        // Client 0 sends A1 A2 A3 with eth always ready.
        bb[0] = 8'hA1; bb[1] = 8'hA2; bb[2] = 8'hA3;
        wready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wd[0] = bb[k]; wvalid[0] = 1'b1; wlast[0] = (k == 2);
            settle();
            check("t2_grant", o_grant, 3'b001);
            check("t2_wdata", o_wdata, bb[k]);
            check("t2_wvalid", o_wvalid, 1);
            check("t2_wlast", o_wlast, (k == 2) ? 1 : 0);
            check("t2_wready", o_wready, 3'b001);
            adv();
        end
        req = 3'b010; wvalid = '0; wlast = '0;
        settle();
        check("t2_bubble_grant", o_grant, 0);
        check("t2_bubble_busy", o_busy, 0);
        check("t2_bubble_wvalid", o_wvalid, 0);
        adv();

        // Client 1 sends B1..B4 while eth ready toggles 1,0,1,0...
        bb[0] = 8'hB1; bb[1] = 8'hB2; bb[2] = 8'hB3; bb[3] = 8'hB4;
        nb = 0; ncap = 0;
        for (int c = 0; c < 20 && nb < 4; c++) begin
            wready = ((c % 2) == 0);
            wd[1] = bb[nb]; wvalid[1] = 1'b1; wlast[1] = (nb == 3);
            settle();
            if (c == 0) check("t3_grant", o_grant, 3'b010);
            check("t3_wdata_stable", o_wdata, bb[nb]);
            check("t3_wready", o_wready, wready ? 3'b010 : 3'b000);
            check("t3_wlast", o_wlast, (nb == 3) ? 1 : 0);
            if (o_wvalid && wready && ncap < 8) begin
                cap[ncap] = o_wdata;
                ncap++;
            end
            adv();
            if (wready) nb++;
        end
        check("t3_count", ncap, 4);
        for (int i = 0; i < 4; i++) check("t3_stream", cap[i], bb[i]);
        req = 3'b011; wvalid = '0; wlast = '0; wready = 1'b1;
        settle();
        check("t3_bubble_grant", o_grant, 0);
        adv();

        // Watchdog: client 0 granted, never valid -> abort after 16 XFER cycles.
        for (int c = 0; c < TO; c++) begin
            settle();
            check("t4_grant_held", o_grant, 3'b001);
            check("t4_no_abort_yet", o_abort, 0);
            adv();
        end
        settle();
        check("t4_abort_pulse", o_abort, 3'b001);
        check("t4_abort_grant", o_grant, 0);
        check("t4_abort_busy", o_busy, 0);
        adv();

        // Client 1 next; last beat lands on the expiry cycle -> no abort.
        for (int c = 0; c < TO; c++) begin
            if (c == TO - 1) begin
                wd[1] = 8'hC5; wvalid[1] = 1'b1; wlast[1] = 1'b1;
            end
            settle();
            if (c == 0) check("t5_grant", o_grant, 3'b010);
            check("t5_abort_pulse_single", o_abort, 0);
            if (c == TO - 1) check("t5_wlast", o_wlast, 1);
            adv();
        end
        wvalid = '0; wlast = '0;
        settle();
        check("t5_no_abort", o_abort, 0);
        check("t5_release", o_grant, 0);
        adv();

        // Client 0: an accepted non-last beat restarts the watchdog.
        for (int c = 0; c < 11 + TO; c++) begin
            wvalid[0] = (c == 10); wd[0] = 8'hD0; wlast[0] = 1'b0;
            settle();
            if (c == 0) check("t4b_grant", o_grant, 3'b001);
            check("t4b_no_abort", o_abort, 0);
            adv();
        end
        wvalid = '0;
        settle();
        check("t4b_abort", o_abort, 3'b001);
        check("t4b_grant_clr", o_grant, 0);
        adv();

        // Reset mid-frame while client 1 is sending.
        wd[1] = 8'hE1; wvalid[1] = 1'b1;
        settle();
        check("t6_pre_grant", o_grant, 3'b010);
        check("t6_pre_wdata", o_wdata, 8'hE1);
        adv();
        rst = 1'b1;
        settle();
        check("t6_pre_reset_grant", o_grant, 3'b010);
        adv();
        wvalid = '0;
        settle();
        check("t6_rst_grant", o_grant, 0);
        check("t6_rst_wvalid", o_wvalid, 0);
        check("t6_rst_busy", o_busy, 0);
        adv();
        rst = 1'b0;
        settle();
        check("t6_idle", o_grant, 0);
        adv();

        // Client 0 wins first after reset, then drops its request mid-frame.
        wd[0] = 8'hF1; wvalid[0] = 1'b1; req = 3'b010;
        settle();
        check("t6_first_after_rst", o_grant, 3'b001);
        check("drop_trunc_wvalid", o_wvalid, 0);
        adv();
        wvalid = '0;
        settle();
        check("drop_release", o_grant, 0);
        check("drop_no_abort", o_abort, 0);
        adv();
        settle();
        check("drop_next_grant", o_grant, 3'b010);
        adv();

        // Randomized frames from all clients, eth ready random.
        rst = 1'b1; req = '0; wvalid = '0; wlast = '0;
        adv(); adv();
        rst = 1'b0;
        for (int n = 0; n < N; n++) begin
            nfr[n] = $urandom_range(4, 2);
            clen[n] = 0; cpos[n] = 0; fdone[n] = 0;
            for (int f = 0; f < nfr[n]; f++) begin
                fst[n][f] = clen[n];
                fln[n][f] = $urandom_range(5, 1);
                for (int b = 0; b < fln[n][f]; b++) begin
                    cdat[n][clen[n]]  = 8'($urandom);
                    clast[n][clen[n]] = (b == fln[n][f] - 1);
                    clen[n]++;
                end
            end
        end
        // Expected order: every client keeps requesting while it has frames,
        // so each frame goes to the first pending client after the last owner.
        en = 0; rptr = N - 1; left = 0;
        for (int n = 0; n < N; n++) left += nfr[n];
        while (left > 0) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && fdone[(rptr + k) % N] < nfr[(rptr + k) % N]) pick = (rptr + k) % N;
            end
            for (int b = 0; b < fln[pick][fdone[pick]]; b++) begin
                exp_own[en] = pick;
                exp_dat[en] = cdat[pick][fst[pick][fdone[pick]] + b];
                exp_lst[en] = clast[pick][fst[pick][fdone[pick]] + b];
                en++;
            end
            fdone[pick]++;
            rptr = pick;
            left--;
        end

        ei = 0; stall = 0; after_last = 1'b0;
        for (int cyc = 0; cyc < 3000 && ei < en; cyc++) begin
            go = (stall >= 8);
            for (int n = 0; n < N; n++) begin
                if (cpos[n] < clen[n]) begin
                    req[n] = 1'b1;
                    wvalid[n] = go || ($urandom_range(3) != 0);
                    wd[n] = cdat[n][cpos[n]];
                    wlast[n] = clast[n][cpos[n]];
                end else begin
                    req[n] = 1'b0;
                    wvalid[n] = 1'($urandom_range(1));
                    wd[n] = 8'($urandom);
                    wlast[n] = 1'($urandom_range(1));
                end
            end
            wready = go || ($urandom_range(3) != 0);
            settle();
            check("r_no_abort", o_abort, 0);
            if (after_last) begin
                check("r_bubble_grant", o_grant, 0);
                check("r_bubble_busy", o_busy, 0);
            end
            if (o_busy && ei < en) begin
                oh = N'(1 << exp_own[ei]);
                check("r_grant_owner", o_grant, oh);
                check("r_wready", o_wready, wready ? oh : '0);
            end else begin
                check("r_idle_grant", o_grant, 0);
                check("r_idle_wready", o_wready, 0);
            end
            if (o_wvalid && wready) begin
                if (ei < en) begin
                    check("r_wdata", o_wdata, exp_dat[ei]);
                    check("r_wlast", o_wlast, exp_lst[ei]);
                    after_last = exp_lst[ei];
                end else begin
                    check("r_extra_beat", 1, 0);
                    after_last = 1'b0;
                end
                ei++;
                stall = 0;
            end else begin
                after_last = 1'b0;
                stall = o_busy ? stall + 1 : 0;
            end
            for (int n = 0; n < N; n++) begin
                if (cpos[n] < clen[n] && wvalid[n] && o_wready[n]) cpos[n]++;
            end
            adv();
        end
        check("r_all_bytes", ei, en);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
